// File: rtl/aclk_timegen_param.sv
// aclk_timegen_param: parametrised second/minute/hour strobe generator with fast-watch and run control.
// Optional HALF_SEC_EN adds a half_second strobe (two per second) for colon blink; CLK_PER_SEC must be even then.
module aclk_timegen_param #(
  parameter int CLK_PER_SEC  = 256,
  parameter int SEC_PER_MIN  = 60,
  parameter int MIN_PER_HOUR = 60,
  parameter int TW           = $clog2(CLK_PER_SEC)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reset_count,
  input  logic       enable,
  input  logic       fastwatch,
  output logic       one_second,
  output logic       one_minute,
  output logic       one_hour,
`ifdef HALF_SEC_EN
  output logic       half_second,
`endif
  output logic [5:0] sec_value,
  output logic [5:0] min_value
);
  logic [TW-1:0] r_cyc;
  logic          w_sec_evt;
  logic          w_min_evt;
  logic          w_sec_wrap;
  logic          w_min_wrap;
  assign w_sec_evt  = r_cyc == TW'(CLK_PER_SEC - 1);
  assign w_sec_wrap = sec_value == 6'(SEC_PER_MIN - 1);
  assign w_min_wrap = min_value == 6'(MIN_PER_HOUR - 1);
  // in fast mode every second event is also a minute event
  assign w_min_evt  = w_sec_evt && (fastwatch || w_sec_wrap);
  always_ff @(posedge clock or posedge reset) begin
    if (reset || reset_count) begin
      r_cyc      <= '0;
      sec_value  <= '0;
      min_value  <= '0;
      one_second <= 1'b0;
      one_minute <= 1'b0;
      one_hour   <= 1'b0;
    end else if (!enable) begin
      one_second <= 1'b0;
      one_minute <= 1'b0;
      one_hour   <= 1'b0;
    end else begin
      r_cyc      <= w_sec_evt ? '0 : r_cyc + TW'(1);
      sec_value  <= fastwatch ? '0 : !w_sec_evt ? sec_value : w_sec_wrap ? '0 : sec_value + 6'd1;
      min_value  <= !w_min_evt ? min_value : w_min_wrap ? '0 : min_value + 6'd1;
      one_second <= w_sec_evt;
      one_minute <= w_min_evt;
      one_hour   <= w_min_evt && w_min_wrap;
    end
  end
`ifdef HALF_SEC_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset || reset_count)
      half_second <= 1'b0;
    else
      half_second <= enable && (w_sec_evt || r_cyc == TW'(CLK_PER_SEC / 2 - 1));
  end
`endif
endmodule

// File: tb/tb_aclk_timegen_param.sv
// tb_aclk_timegen_param: segment table plus per-cycle scoreboard for aclk_timegen_param (CLK=4, SEC=3, MIN=2).
module tb_aclk_timegen_param;
  localparam int CPS = 4;
  localparam int SPM = 3;
  localparam int MPH = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reset_count = 1'b0;
  logic enable = 1'b0;
  logic fastwatch = 1'b0;
  logic one_second, one_minute, one_hour, w_hs;
  logic [5:0] sec_value, min_value;
  aclk_timegen_param #(.CLK_PER_SEC(CPS), .SEC_PER_MIN(SPM), .MIN_PER_HOUR(MPH)) dut (
    .clock(clock), .reset(reset), .reset_count(reset_count), .enable(enable), .fastwatch(fastwatch),
    .one_second(one_second), .one_minute(one_minute), .one_hour(one_hour),
`ifdef HALF_SEC_EN
    .half_second(w_hs),
`endif
    .sec_value(sec_value), .min_value(min_value)
  );
`ifndef HALF_SEC_EN
  assign w_hs = 1'b0;
`endif
  always #5 clock = ~clock;
  typedef struct packed {logic os, om, oh, hs; logic [5:0] sec, mn;} exp_t;
  typedef struct {logic rc, en, fw; int n, nsec, sec, mn;} seg_t;
  exp_t q[$];
  seg_t tbl[11];
  int n_chk = 0, n_pass = 0;
  int m_cyc = 0, m_sec = 0, m_min = 0;
  int cyc_idx = 0, first_os = -1, first_oh = -1, seg_os = 0;
  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, want, cyc_idx);
  endtask
  task automatic model_step(input logic rc, input logic en, input logic fw);
    exp_t e = '0;
    if (rc) begin
      m_cyc = 0; m_sec = 0; m_min = 0;
    end else if (en) begin
`ifdef HALF_SEC_EN
      e.hs = (m_cyc == CPS / 2 - 1) || (m_cyc == CPS - 1);
`endif
      m_cyc++;
      if (m_cyc == CPS) begin
        m_cyc = 0;
        e.os = 1'b1;
        if (fw) begin
          m_sec = 0; e.om = 1'b1;
        end else begin
          m_sec++;
          if (m_sec == SPM) begin m_sec = 0; e.om = 1'b1; end
        end
        if (e.om) begin
          m_min++;
          if (m_min == MPH) begin m_min = 0; e.oh = 1'b1; end
        end
      end else if (fw) m_sec = 0;
    end
    e.sec = 6'(m_sec);
    e.mn = 6'(m_min);
    q.push_back(e);
  endtask
  task automatic tick(input logic rc, input logic en, input logic fw);
    exp_t e;
    reset_count = rc; enable = en; fastwatch = fw;
    model_step(rc, en, fw);
    @(posedge clock);
    #1;
    cyc_idx++;
    if (one_second) seg_os++;
    if (one_second && first_os < 0) first_os = cyc_idx;
    if (one_hour && first_oh < 0) first_oh = cyc_idx;
    if (q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      e = q.pop_front();
      chk("outputs{os,om,oh,hs,sec,min}", {one_second, one_minute, one_hour, w_hs, sec_value, min_value}, e);
    end
    @(negedge clock);
  endtask
  initial begin
    tbl[0]  = '{0, 1, 0, 24, 6, 0, 0};
    tbl[1]  = '{0, 1, 0, 6, 1, 1, 0};
    tbl[2]  = '{0, 0, 0, 5, 0, 1, 0};
    tbl[3]  = '{0, 1, 0, 2, 1, 2, 0};
    tbl[4]  = '{0, 1, 0, 3, 0, 2, 0};
    tbl[5]  = '{1, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 0, 4, 1, 1, 0};
    tbl[7]  = '{0, 1, 1, 8, 2, 0, 0};
    tbl[8]  = '{0, 1, 1, 4, 1, 0, 1};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 1, 0, 12, 3, 0, 1};
    repeat (2) @(negedge clock);
    chk("reset_state", {one_second, one_minute, one_hour, w_hs, sec_value, min_value}, 0);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      seg_os = 0;
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].rc, tbl[i].en, tbl[i].fw);
      chk($sformatf("seg%0d_seconds", i), seg_os, tbl[i].nsec);
      chk($sformatf("seg%0d_sec_value", i), sec_value, tbl[i].sec);
      chk($sformatf("seg%0d_min_value", i), min_value, tbl[i].mn);
      if (i == 0) begin
        chk("first_one_second_cycle", first_os, 4);
        chk("first_one_hour_cycle", first_oh, 24);
      end
    end
    repeat (4) tick(0, 1, 0);
    chk("pre_async_sec_value", sec_value, 1);
    #2 reset = 1'b1;
    #1 chk("async_reset_clear", {one_second, one_minute, one_hour, w_hs, sec_value, min_value}, 0);
    m_cyc = 0; m_sec = 0; m_min = 0;
    @(negedge clock);
    reset = 1'b0;
    seg_os = 0;
    repeat (3) tick(0, 1, 0);
    chk("restart_no_early_second", seg_os, 0);
    tick(0, 1, 0);
    chk("restart_second_after_4", seg_os, 1);
    repeat (8) tick(0, 1, $urandom_range(0, 1) == 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
